// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port-0 arbiter: macro geometry, owner encoding
// and the per-requester command bundle.
package sram_arb_pkg;

   localparam int SRAM_AW    = 9;
   localparam int SRAM_DW    = 32;
   localparam int SRAM_MASKW = 4;

   typedef enum logic {
      OWN_R0 = 1'b0,
      OWN_R1 = 1'b1
   } owner_e;

   typedef struct packed {
      logic                  we;
      logic [SRAM_MASKW-1:0] wmask;
      logic [SRAM_AW-1:0]    addr;
      logic [SRAM_DW-1:0]    wdata;
   } sram_req_t;

endpackage

// File: rtl/sram_port0_arbiter_wrr.sv
// Weighted round-robin grant for the two port-0 requesters; r0 may win up to
// R0_WEIGHT consecutive contested cycles before r1 is served.
module sram_arb_wrr
   import sram_arb_pkg::*;
#(
   parameter int unsigned R0_WEIGHT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic r0_valid,
   input  logic r1_valid,
   output logic gnt_r0,
   output logic gnt_r1
);

   localparam logic [3:0] WEIGHT = 4'(R0_WEIGHT);

   logic [3:0] burst_cnt_q, burst_cnt_d;
   owner_e     last_gnt_q, last_gnt_d;
   logic       r1_turn;

   always_comb begin
      gnt_r0      = 1'b0;
      gnt_r1      = 1'b0;
      burst_cnt_d = 4'd0;
      last_gnt_d  = last_gnt_q;
      // A nonzero burst can only follow r0 grants, so the owner term never changes the outcome.
      r1_turn     = (burst_cnt_q >= WEIGHT) && (last_gnt_q == OWN_R0);

      if (!rst) begin
         if (r0_valid && r1_valid) begin
            gnt_r1 = r1_turn;
            gnt_r0 = !r1_turn;
         end else begin
            gnt_r0 = r0_valid;
            gnt_r1 = r1_valid;
         end
      end

      if (gnt_r0) begin
         last_gnt_d  = OWN_R0;
         burst_cnt_d = (burst_cnt_q >= WEIGHT) ? WEIGHT : burst_cnt_q + 4'd1;
      end else if (gnt_r1) begin
         last_gnt_d  = OWN_R1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt_q <= 4'd0;
         last_gnt_q  <= OWN_R1;
      end else begin
         burst_cnt_q <= burst_cnt_d;
         last_gnt_q  <= last_gnt_d;
      end
   end

endmodule

// File: rtl/sram_port0_arbiter.sv
// Shares the RW port of a sky130 1rw1r SRAM between a Wishbone path (r0) and a
// core/DMA path (r1). Optional stall counters: SRAM_PORT0_ARBITER_PERF_CNT_EN.
module sram_port0_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW        = SRAM_AW,
   parameter int DW        = SRAM_DW,
   parameter int R0_WEIGHT = 2
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,

   input  logic          r0_valid,
   output logic          r0_ready,
   input  logic          r0_we,
   input  logic [3:0]    r0_wmask,
   input  logic [AW-1:0] r0_addr,
   input  logic [DW-1:0] r0_wdata,
   output logic          r0_rsp_valid,
   output logic [DW-1:0] r0_rsp_rdata,

   input  logic          r1_valid,
   output logic          r1_ready,
   input  logic          r1_we,
   input  logic [3:0]    r1_wmask,
   input  logic [AW-1:0] r1_addr,
   input  logic [DW-1:0] r1_wdata,
   output logic          r1_rsp_valid,
   output logic [DW-1:0] r1_rsp_rdata,

   output logic          sram_csb0,
   output logic          sram_web0,
   output logic [3:0]    sram_wmask0,
   output logic [AW-1:0] sram_addr0,
   output logic [DW-1:0] sram_din0,
   input  logic [DW-1:0] sram_dout0
`ifdef SRAM_PORT0_ARBITER_PERF_CNT_EN
   ,
   input  logic          perf_clr,
   output logic [15:0]   r0_stall_cnt,
   output logic [15:0]   r1_stall_cnt
`endif
);

   logic      gnt_r0, gnt_r1;
   sram_req_t r0_req, r1_req, sel_req;

   logic      rsp_pend_q, rsp_pend_d;
   owner_e    rsp_owner_q, rsp_owner_d;
   logic      rsp_is_rd_q, rsp_is_rd_d;
   logic [DW-1:0] rsp_data;

   sram_arb_wrr #(
      .R0_WEIGHT (R0_WEIGHT)
   ) u_wrr (
      .clk      (wb_clk_i),
      .rst      (wb_rst_i),
      .r0_valid (r0_valid),
      .r1_valid (r1_valid),
      .gnt_r0   (gnt_r0),
      .gnt_r1   (gnt_r1)
   );

   assign r0_ready = gnt_r0;
   assign r1_ready = gnt_r1;

   always_comb begin
      r0_req = '{we: r0_we, wmask: r0_wmask, addr: r0_addr, wdata: r0_wdata};
      r1_req = '{we: r1_we, wmask: r1_wmask, addr: r1_addr, wdata: r1_wdata};
      sel_req = '0;
      if (gnt_r0) begin
         sel_req = r0_req;
      end else if (gnt_r1) begin
         sel_req = r1_req;
      end
   end

   // Idle cycles park the bus at zero with both strobes deasserted.
   always_comb begin
      sram_csb0   = !(gnt_r0 || gnt_r1);
      sram_web0   = sram_csb0 ? 1'b1 : !sel_req.we;
      sram_wmask0 = sel_req.wmask;
      sram_addr0  = sel_req.addr;
      sram_din0   = sel_req.wdata;
   end

   always_comb begin
      rsp_pend_d  = gnt_r0 || gnt_r1;
      rsp_owner_d = gnt_r1 ? OWN_R1 : OWN_R0;
      rsp_is_rd_d = (gnt_r0 || gnt_r1) && !sel_req.we;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         rsp_pend_q  <= 1'b0;
         rsp_owner_q <= OWN_R0;
         rsp_is_rd_q <= 1'b0;
      end else begin
         rsp_pend_q  <= rsp_pend_d;
         rsp_owner_q <= rsp_owner_d;
         rsp_is_rd_q <= rsp_is_rd_d;
      end
   end

   // The macro presents read data in the cycle after capture; forward it untouched.
   always_comb begin
      rsp_data     = rsp_is_rd_q ? sram_dout0 : '0;
      r0_rsp_valid = rsp_pend_q && (rsp_owner_q == OWN_R0);
      r1_rsp_valid = rsp_pend_q && (rsp_owner_q == OWN_R1);
      r0_rsp_rdata = r0_rsp_valid ? rsp_data : '0;
      r1_rsp_rdata = r1_rsp_valid ? rsp_data : '0;
   end

`ifdef SRAM_PORT0_ARBITER_PERF_CNT_EN
   logic [15:0] r0_stall_q, r0_stall_d;
   logic [15:0] r1_stall_q, r1_stall_d;

   always_comb begin
      r0_stall_d = r0_stall_q;
      r1_stall_d = r1_stall_q;
      if (perf_clr) begin
         r0_stall_d = 16'd0;
         r1_stall_d = 16'd0;
      end else begin
         if (r0_valid && !r0_ready && (r0_stall_q != 16'hFFFF)) r0_stall_d = r0_stall_q + 16'd1;
         if (r1_valid && !r1_ready && (r1_stall_q != 16'hFFFF)) r1_stall_d = r1_stall_q + 16'd1;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r0_stall_q <= 16'd0;
         r1_stall_q <= 16'd0;
      end else begin
         r0_stall_q <= r0_stall_d;
         r1_stall_q <= r1_stall_d;
      end
   end

   assign r0_stall_cnt = r0_stall_q;
   assign r1_stall_cnt = r1_stall_q;
`endif

endmodule
